// File: rtl/robo_ambiente.sv
// robo_ambiente: grid-world plant for the wall-following robot controller.
// Executes avancar/girar commands on an 8x8 obstacle map with timed moves and
// turns, and reports registered head/left wall sensors.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   avancar, girar     forward / turn-right commands (level, sampled in IDLE)
//   mapa[63:0]         obstacle map, bit y*8+x set = cell (x,y) is a wall
//   head, left         registered wall sensors (ahead / to the left)
//   pos_x, pos_y, dir  current cell and heading (0=N,1=E,2=S,3=W)
//   ocupado            high while a move or turn executes
//   colisao            one-cycle pulse: forward refused, cell ahead blocked
//   passos[15:0]       saturating count of completed forward moves
//   visitado[63:0]     visited-cell bitmap; only populated when the macro
//                      ROBO_VISITADO_EN is defined, otherwise constant zero
module robo_ambiente #(
  parameter int unsigned START_X     = 0,
  parameter int unsigned START_Y     = 0,
  parameter int unsigned START_DIR   = 0,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avancar,
  input  logic        girar,
  input  logic [63:0] mapa,
  output logic        head,
  output logic        left,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [1:0]  dir,
  output logic        ocupado,
  output logic        colisao,
  output logic [15:0] passos,
  output logic [63:0] visitado
);

  typedef enum logic [1:0] {IDLE, MOVING, TURNING} state_t;

  typedef struct packed {
    logic       oob;
    logic [2:0] x;
    logic [2:0] y;
  } cell_t;

  localparam int unsigned CNT_MAX = (MOVE_CYCLES > TURN_CYCLES) ? MOVE_CYCLES : TURN_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Neighbour cell in heading d. The 3-bit coordinates wrap, but oob flags
  // that case so the wrapped value is never used as a real position.
  function automatic cell_t neighbour(input logic [2:0] x, input logic [2:0] y,
                                      input logic [1:0] d);
    cell_t c;
    c.x   = x;
    c.y   = y;
    c.oob = 1'b0;
    unique case (d)
      2'd0: begin c.oob = (y == 3'd7); c.y = y + 3'd1; end
      2'd1: begin c.oob = (x == 3'd7); c.x = x + 3'd1; end
      2'd2: begin c.oob = (y == 3'd0); c.y = y - 3'd1; end
      2'd3: begin c.oob = (x == 3'd0); c.x = x - 3'd1; end
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    tgt_x, tgt_y;
  cell_t         ahead_c, left_c;
  logic          ahead_wall, left_wall;
  logic          accept_move, accept_turn, refuse, done_move, done_turn;

  always_comb begin
    ahead_c    = neighbour(pos_x, pos_y, dir);
    left_c     = neighbour(pos_x, pos_y, dir - 2'd1);
    ahead_wall = ahead_c.oob | mapa[{ahead_c.y, ahead_c.x}];
    left_wall  = left_c.oob  | mapa[{left_c.y, left_c.x}];
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept_move = 1'b0;
    accept_turn = 1'b0;
    refuse      = 1'b0;
    done_move   = 1'b0;
    done_turn   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (girar) begin
          state_d     = TURNING;
          accept_turn = 1'b1;
        end else if (avancar) begin
          if (ahead_wall) begin
            refuse = 1'b1;
          end else begin
            state_d     = MOVING;
            accept_move = 1'b1;
          end
        end
      end
      MOVING: begin
        if (cnt == '0) begin
          state_d   = IDLE;
          done_move = 1'b1;
        end
      end
      TURNING: begin
        if (cnt == '0) begin
          state_d   = IDLE;
          done_turn = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ocupado = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x   <= 3'(START_X);
      pos_y   <= 3'(START_Y);
      dir     <= 2'(START_DIR);
      cnt     <= '0;
      tgt_x   <= '0;
      tgt_y   <= '0;
      colisao <= 1'b0;
      passos  <= '0;
      head    <= 1'b0;
      left    <= 1'b0;
    end else begin
      head    <= ahead_wall;
      left    <= left_wall;
      colisao <= refuse;
      if (accept_move) begin
        cnt   <= CW'(MOVE_CYCLES - 1);
        // Target latched here so later mapa changes cannot abort the move.
        tgt_x <= ahead_c.x;
        tgt_y <= ahead_c.y;
      end else if (accept_turn) begin
        cnt <= CW'(TURN_CYCLES - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done_move) begin
        pos_x <= tgt_x;
        pos_y <= tgt_y;
        if (passos != '1) passos <= passos + 16'd1;
      end
      if (done_turn) dir <= dir + 2'd1;
    end
  end

`ifdef ROBO_VISITADO_EN
  always_ff @(posedge clock) begin
    if (reset)          visitado <= 64'(1) << (START_Y * 8 + START_X);
    else if (done_move) visitado[{tgt_y, tgt_x}] <= 1'b1;
  end
`else
  assign visitado = '0;
`endif

endmodule

// File: tb/tb_robo_ambiente.sv
module tb_robo_ambiente;

  localparam int SX = 0;
  localparam int SY = 0;
  localparam int SD = 0;
  localparam int MC = 4;
  localparam int TC = 2;

  logic        clock = 1'b0;
  logic        reset, avancar, girar;
  logic [63:0] mapa;
  logic        head, left, ocupado, colisao;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic [15:0] passos;
  logic [63:0] visitado;

  robo_ambiente #(
    .START_X(SX), .START_Y(SY), .START_DIR(SD),
    .MOVE_CYCLES(MC), .TURN_CYCLES(TC)
  ) dut (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
    .mapa(mapa), .head(head), .left(left), .pos_x(pos_x), .pos_y(pos_y),
    .dir(dir), .ocupado(ocupado), .colisao(colisao), .passos(passos),
    .visitado(visitado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: robot as integer coordinates with a remaining-busy count.
  int          DX[4] = '{0, 1, 0, -1};
  int          DY[4] = '{1, 0, -1, 0};
  int          mx, my, md, busy, kind, tx, ty, mpass;
  logic        mhead, mleft, mcol;
  logic [63:0] mvis;

  function automatic bit is_wall(input int x, input int y, input logic [63:0] m);
    if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
    return m[y*8 + x];
  endfunction

  task automatic model_step();
    logic nh, nl;
    if (reset) begin
      mx = SX; my = SY; md = SD; busy = 0; mpass = 0;
      mhead = 0; mleft = 0; mcol = 0;
      mvis = '0; mvis[SY*8 + SX] = 1'b1;
    end else begin
      nh   = is_wall(mx + DX[md], my + DY[md], mapa);
      nl   = is_wall(mx + DX[(md+3)%4], my + DY[(md+3)%4], mapa);
      mcol = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (kind == 0) begin
            mx = tx; my = ty;
            if (mpass < 65535) mpass++;
            mvis[my*8 + mx] = 1'b1;
          end else begin
            md = (md + 1) % 4;
          end
        end
      end else if (girar) begin
        busy = TC; kind = 1;
      end else if (avancar) begin
        if (is_wall(mx + DX[md], my + DY[md], mapa)) mcol = 1;
        else begin
          busy = MC; kind = 0; tx = mx + DX[md]; ty = my + DY[md];
        end
      end
      mhead = nh; mleft = nl;
    end
  endtask

  task automatic check_model();
    chk("m_pos_x",   64'(pos_x),   64'(mx));
    chk("m_pos_y",   64'(pos_y),   64'(my));
    chk("m_dir",     64'(dir),     64'(md));
    chk("m_ocupado", 64'(ocupado), 64'(busy > 0));
    chk("m_colisao", 64'(colisao), 64'(mcol));
    chk("m_passos",  64'(passos),  64'(mpass));
    chk("m_head",    64'(head),    64'(mhead));
    chk("m_left",    64'(left),    64'(mleft));
`ifdef ROBO_VISITADO_EN
    chk("m_visitado", visitado, mvis);
`else
    chk("m_visitado", visitado, 64'h0);
`endif
  endtask

  task automatic tick(input logic r, input logic a, input logic g);
    reset = r; avancar = a; girar = g;
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_idle(output int nbusy);
    int n;
    nbusy = ocupado ? 1 : 0;
    n = 0;
    while (ocupado && n < 50) begin
      tick(0, 0, 0);
      n++;
      if (ocupado) nbusy++;
    end
    total++;
    if (ocupado) begin
      bad++;
      $display("FAIL wait_idle: ocupado still %0b after %0d cycles", ocupado, n);
    end
  endtask

  typedef struct {
    logic        rst, av, gi;
    logic [63:0] m;
    logic        ocup, col, hd, lf;
    logic [2:0]  x, y;
    logic [1:0]  d;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, av, gi, input logic [63:0] m,
                              input logic ocup, col, hd, lf,
                              input logic [2:0] x, y, input logic [1:0] d,
                              input logic [15:0] p);
    vec_t v;
    v.rst = rst; v.av = av; v.gi = gi; v.m = m;
    v.ocup = ocup; v.col = col; v.hd = hd; v.lf = lf;
    v.x = x; v.y = y; v.d = d; v.p = p;
    return v;
  endfunction

  initial begin
    int nb, n;
    reset = 1; avancar = 0; girar = 0; mapa = '0;

    //           rst av gi mapa      ocu col hd lf x y d p
    tbl.push_back(mk(1, 0, 0, 64'h0,   0, 0, 0, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 0, 0, 64'h0,   0, 0, 0, 1, 0, 0, 0, 0)); // sensors valid
    tbl.push_back(mk(0, 1, 0, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0)); // move accepted
    tbl.push_back(mk(0, 0, 0, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,   0, 0, 0, 1, 0, 1, 0, 1)); // move done
    tbl.push_back(mk(0, 0, 0, 64'h0,   0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 64'h100, 0, 0, 0, 0, 0, 0, 0, 0)); // reset, wall at (0,1)
    tbl.push_back(mk(0, 1, 0, 64'h100, 0, 1, 1, 1, 0, 0, 0, 0)); // collisions x3
    tbl.push_back(mk(0, 1, 0, 64'h100, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h100, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h100, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0)); // both: turn wins
    tbl.push_back(mk(0, 0, 0, 64'h0,   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,   0, 0, 0, 1, 0, 0, 1, 0)); // facing E
    tbl.push_back(mk(0, 0, 0, 64'h0,   0, 0, 0, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      mapa = tbl[i].m;
      tick(tbl[i].rst, tbl[i].av, tbl[i].gi);
      chk("t_ocupado", 64'(ocupado), 64'(tbl[i].ocup));
      chk("t_colisao", 64'(colisao), 64'(tbl[i].col));
      chk("t_head",    64'(head),    64'(tbl[i].hd));
      chk("t_left",    64'(left),    64'(tbl[i].lf));
      chk("t_pos_x",   64'(pos_x),   64'(tbl[i].x));
      chk("t_pos_y",   64'(pos_y),   64'(tbl[i].y));
      chk("t_dir",     64'(dir),     64'(tbl[i].d));
      chk("t_passos",  64'(passos),  64'(tbl[i].p));
      if (i == 6) begin
`ifdef ROBO_VISITADO_EN
        chk("t_visitado", visitado, 64'h0101);
`else
        chk("t_visitado", visitado, 64'h0);
`endif
      end
    end

    // Four turns: two busy cycles each, heading 1,2,3,0.
    mapa = '0;
    tick(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 1);
      wait_idle(nb);
      chk("turn_busy", 64'(nb), 64'(TC));
      chk("turn_dir", 64'(dir), 64'((k + 1) % 4));
    end

    // Drive to the east edge, then push into it.
    tick(1, 0, 0);
    tick(0, 0, 1);
    wait_idle(nb);
    n = 0;
    while (pos_x != 3'd7 && n < 100) begin
      tick(0, 1, 0);
      n++;
    end
    chk("edge_reached", 64'(pos_x), 64'd7);
    tick(0, 0, 0);
    wait_idle(nb);
    tick(0, 0, 0);
    chk("edge_head", 64'(head), 64'd1);
    chk("edge_passos", 64'(passos), 64'd7);
    tick(0, 1, 0);
    chk("edge_colisao", 64'(colisao), 64'd1);
    chk("edge_pos_x", 64'(pos_x), 64'd7);
    tick(0, 0, 0);
    chk("edge_colisao_off", 64'(colisao), 64'd0);

    // Reset during the second cycle of a move.
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1);
      wait_idle(nb);
    end
    chk("face_n", 64'(dir), 64'd0);
    tick(0, 1, 0);
    chk("mv_busy", 64'(ocupado), 64'd1);
    tick(0, 0, 0);
    tick(1, 0, 0);
    chk("rst_mid_x", 64'(pos_x), 64'(SX));
    chk("rst_mid_y", 64'(pos_y), 64'(SY));
    chk("rst_mid_ocupado", 64'(ocupado), 64'd0);
    chk("rst_mid_passos", 64'(passos), 64'd0);

    // Random closed loop against the model.
    tick(0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0)
        mapa = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      tick($urandom_range(0, 699) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robo_ambiente.md
Name: robo_ambiente

Overview:
- Synthesizable world/actuator model for the wall-following robot controller. It is the other end of the controller's command/sensor interface.
- Consumes the `avancar`/`girar` commands and executes them on an 8x8 grid map with timed moves and turns.
- Returns registered `head`/`left` wall-sensor bits.
- Used as the plant in closed-loop benches and FPGA demos.

Parameters:
- START_X, 0, initial column (0..7)
- START_Y, 0, initial row (0..7)
- START_DIR, 0, initial heading: 0=N, 1=E, 2=S, 3=W
- MOVE_CYCLES, 4, cycles a forward move takes (>=1)
- TURN_CYCLES, 2, cycles a 90° turn takes (>=1)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- avancar  input  1  forward command, level, sampled only in IDLE
- girar  input  1  turn-right command, level, sampled only in IDLE
- mapa  input  64  obstacle map; bit y*8+x = 1 means cell (x,y) is a wall
- head  output  1  wall directly ahead (registered)
- left  output  1  wall directly to the left (registered)
- pos_x  output  3  current column
- pos_y  output  3  current row
- dir  output  2  current heading
- ocupado  output  1  high while a move or turn is executing
- colisao  output  1  one-cycle pulse: forward command refused, cell ahead blocked
- passos  output  16  count of completed forward moves, saturating
- visitado  output  64  visited-cell bitmap (optional feature)

Behaviour:

Reset:
- Reset is synchronous and active-high, on `clock`. It overrides everything, including a move or turn in progress.
- Reset values: pos=(START_X,START_Y), dir=START_DIR, state=IDLE, ocupado=0, colisao=0, passos=0, head=0, left=0.
- head/left become valid on the first edge after reset deasserts.

Geometry:
- Step vectors by heading: N y+1, E x+1, S y-1, W x-1.
- Ahead cell = pos + step(dir). Left cell = pos + step((dir+3) mod 4).
- Any cell outside 0..7 on either axis counts as a wall. There is no wrap-around.

Sensors:
- head/left are registered from the current pos/dir/mapa every cycle, including while ocupado=1.
- A change in pos, dir or mapa shows on head/left one cycle later.

FSM states: IDLE, MOVING, TURNING.
- IDLE, girar=1 (girar wins over avancar when both are high): go to TURNING. ocupado=1 from the next cycle.
- IDLE, avancar=1 only, ahead cell free: go to MOVING. ocupado=1 from the next cycle.
- IDLE, avancar=1 only, ahead cell is a wall: colisao=1 for exactly one cycle. Stay IDLE; pos and passos unchanged.
  - A held avancar against a wall pulses colisao every cycle it is sampled.
- MOVING:
  - Down-counter loaded with MOVE_CYCLES-1.
  - On the cycle it reaches 0: pos <= ahead cell (as computed at command acceptance), passos <= passos+1 (saturates at 0xFFFF), return to IDLE, ocupado=0.
- TURNING:
  - Same counting with TURN_CYCLES.
  - On completion: dir <= (dir+1) mod 4, return to IDLE, ocupado=0.

Timing and command handling:
- Commands are ignored while ocupado=1.
- A command held high is re-accepted on the first IDLE cycle, so back-to-back commands are separated by exactly one IDLE cycle.
- mapa changes during MOVING do not abort the move; the target cell was latched at acceptance.
- The start cell is never checked against mapa. The robot may sit on a wall cell.

Optional Feature:
- Macro: ROBO_VISITADO_EN.
- Defined:
  - visitado holds a 64-bit register.
  - On reset it is cleared except bit START_Y*8+START_X.
  - Each completed move sets the bit of the new cell. Bits are never cleared except by reset.
- Undefined: visitado is tied to 64'h0 and no register is inferred.

Test Plan:
1. Reset with mapa=0, START=(0,0,N). Release reset -> next cycle head=0, left=1 (west is out of bounds), pos=(0,0), dir=0, ocupado=0.
2. Same setup, avancar pulsed 1 cycle in IDLE -> ocupado=1 for exactly 4 cycles, then pos_y=1, passos=1. One cycle later head=0, left=1. With ROBO_VISITADO_EN: visitado=64'h0101.
3. mapa bit 8 set (cell (0,1)), START=(0,0,N), avancar held 3 cycles -> colisao high 3 cycles, pos stays (0,0), passos=0, head=1.
4. girar pulsed four times, waiting for ocupado=0 between pulses -> each turn is ocupado=1 for 2 cycles; dir sequence 1,2,3,0.
5. avancar=1 and girar=1 in the same IDLE cycle -> turn only: dir=1 after 2 busy cycles, pos and passos unchanged, colisao=0.
6. START=(7,0,E) -> head=1; avancar -> colisao pulse. Separately, assert reset during cycle 2 of a MOVING -> next cycle pos=start, ocupado=0, passos=0.
